// File: rtl/risc_pkg.sv
// Shared types for the memory port arbiter: data access sizes and arbiter FSM states.
package risc_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } op_enum_dmem_size;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_port_arb_if.sv
// Requester and memory-side signal bundle for mem_port_arb.
interface mem_port_arb_if #(
  parameter int AW = 32
);
  import risc_pkg::*;

  logic             if_req;
  logic [AW-1:0]    if_addr;
  logic [31:0]      if_rdata;
  logic             if_ack;
  logic             if_err;

  logic             d_req;
  logic             d_wr;
  op_enum_dmem_size d_size;
  logic             d_zero_ex;
  logic [AW-1:0]    d_addr;
  logic [31:0]      d_wdata;
  logic [31:0]      d_rdata;
  logic             d_ack;
  logic             d_err;

  logic             m_req;
  logic             m_wr;
  logic [3:0]       m_be;
  logic [AW-1:0]    m_addr;
  logic [31:0]      m_wdata;
  logic [31:0]      m_rdata;
  logic             m_ack;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack, if_err,
    input  d_req, d_wr, d_size, d_zero_ex, d_addr, d_wdata,
    output d_rdata, d_ack, d_err,
    output m_req, m_wr, m_be, m_addr, m_wdata,
    input  m_rdata, m_ack
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack, if_err,
    output d_req, d_wr, d_size, d_zero_ex, d_addr, d_wdata,
    input  d_rdata, d_ack, d_err,
    input  m_req, m_wr, m_be, m_addr, m_wdata,
    output m_rdata, m_ack
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: write enables/replication on the request side,
// lane extraction and sign/zero extension on the response side.
module mem_lane_align
  import risc_pkg::*;
(
  input  op_enum_dmem_size req_size,
  input  logic             req_fetch,
  input  logic [1:0]       req_addr_lo,
  input  logic [31:0]      req_wdata,
  output logic [3:0]       be,
  output logic [31:0]      wdata,
  output logic             misalign,

  input  op_enum_dmem_size rsp_size,
  input  logic [1:0]       rsp_addr_lo,
  input  logic             rsp_zero_ex,
  input  logic [31:0]      rsp_rdata,
  output logic [31:0]      rdata
);

  logic [31:0] lane;

  always_comb begin
    be       = 4'b1111;
    wdata    = req_wdata;
    misalign = (req_addr_lo != 2'b00);
    if (!req_fetch) begin
      case (req_size)
        SIZE_BYTE: begin
          be       = 4'b0001 << req_addr_lo;
          wdata    = {4{req_wdata[7:0]}};
          misalign = 1'b0;
        end
        SIZE_HALF: begin
          be       = 4'b0011 << req_addr_lo;
          wdata    = {2{req_wdata[15:0]}};
          misalign = req_addr_lo[0];
        end
        default: ;
      endcase
    end
  end

  assign lane = rsp_rdata >> {rsp_addr_lo, 3'b000};

  always_comb begin
    case (rsp_size)
      SIZE_BYTE: rdata = {{24{~rsp_zero_ex & lane[7]}}, lane[7:0]};
      SIZE_HALF: rdata = {{16{~rsp_zero_ex & lane[15]}}, lane[15:0]};
      default:   rdata = rsp_rdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates an instruction-fetch and a data requester onto one memory port,
// data first, with alignment checking and a per-transaction watchdog.
//
//   state  | meaning
//   IDLE   | waiting for a request; data wins over fetch
//   BUSY_I | fetch issued on m_req, waiting for m_ack or watchdog
//   BUSY_D | data access issued on m_req, waiting for m_ack or watchdog
//   RESP   | one-cycle ack (and err) pulse to the granted requester
module mem_port_arb
  import risc_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst,
  mem_port_arb_if.slave bus
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  arb_state_e       state, state_nxt;
  op_enum_dmem_size lat_size;
  logic             lat_zero_ex;
  logic [1:0]       lat_addr_lo;
  logic [WDW-1:0]   wd_cnt;

  op_enum_dmem_size req_size;
  logic             req_fetch;
  logic [AW-1:0]    req_addr;
  logic [3:0]       req_be;
  logic [31:0]      req_wdata;
  logic [31:0]      rsp_rdata;
  logic             misalign;
  logic             grant, issue, done, fail, resp_d, busy;

  assign req_fetch = ~bus.d_req;
  assign req_size  = bus.d_req ? bus.d_size : SIZE_WORD;
  assign req_addr  = bus.d_req ? bus.d_addr : bus.if_addr;
  assign busy      = (state == BUSY_I) || (state == BUSY_D);

  mem_lane_align u_align (
    .req_size    (req_size),
    .req_fetch   (req_fetch),
    .req_addr_lo (req_addr[1:0]),
    .req_wdata   (bus.d_wdata),
    .be          (req_be),
    .wdata       (req_wdata),
    .misalign    (misalign),
    .rsp_size    (lat_size),
    .rsp_addr_lo (lat_addr_lo),
    .rsp_zero_ex (lat_zero_ex),
    .rsp_rdata   (bus.m_rdata),
    .rdata       (rsp_rdata)
  );

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    fail      = 1'b0;
    resp_d    = (state == BUSY_D);
    case (state)
      IDLE: begin
        if (bus.d_req || bus.if_req) begin
          grant  = 1'b1;
          resp_d = bus.d_req;
          if (misalign) begin
            fail      = 1'b1;
            state_nxt = RESP;
          end else begin
            issue     = 1'b1;
            state_nxt = bus.d_req ? BUSY_D : BUSY_I;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        // m_ack is tested first so an ack on the last watchdog cycle still succeeds
        if (bus.m_ack) begin
          done      = 1'b1;
          state_nxt = RESP;
        end else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
          fail      = 1'b1;
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lat_size     <= SIZE_WORD;
      lat_zero_ex  <= 1'b0;
      lat_addr_lo  <= 2'b00;
      wd_cnt       <= '0;
      bus.m_req    <= 1'b0;
      bus.m_wr     <= 1'b0;
      bus.m_be     <= '0;
      bus.m_addr   <= '0;
      bus.m_wdata  <= '0;
      bus.if_ack   <= 1'b0;
      bus.if_err   <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_ack    <= 1'b0;
      bus.d_err    <= 1'b0;
      bus.d_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      bus.if_ack <= 1'b0;
      bus.if_err <= 1'b0;
      bus.d_ack  <= 1'b0;
      bus.d_err  <= 1'b0;

      if (grant) begin
        lat_size    <= req_size;
        lat_zero_ex <= bus.d_zero_ex;
        lat_addr_lo <= req_addr[1:0];
        wd_cnt      <= '0;
      end else if (busy && !bus.m_ack) begin
        wd_cnt <= wd_cnt + WDW'(1);
      end

      if (issue) begin
        bus.m_req   <= 1'b1;
        bus.m_wr    <= bus.d_req & bus.d_wr;
        bus.m_be    <= req_be;
        bus.m_addr  <= {req_addr[AW-1:2], 2'b00};
        bus.m_wdata <= req_wdata;
      end

      if (done || fail) begin
        bus.m_req <= 1'b0;
        bus.m_wr  <= 1'b0;
        if (resp_d) begin
          bus.d_ack <= 1'b1;
          bus.d_err <= fail;
        end else begin
          bus.if_ack <= 1'b1;
          bus.if_err <= fail;
        end
      end

      if (done) begin
        if (resp_d) bus.d_rdata  <= rsp_rdata;
        else        bus.if_rdata <= bus.m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Randomized transaction bench for mem_port_arb with a byte-level reference model.
module tb_mem_port_arb;
  import risc_pkg::*;

  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  mem_port_arb_if #(.AW(32)) bus ();

  mem_port_arb #(.AW(32), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL sim_time_limit: got expired expected finished");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_wr      = 1'b0;
    bus.d_size    = SIZE_WORD;
    bus.d_zero_ex = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.m_rdata   = '0;
    bus.m_ack     = 1'b0;
  endtask

  function automatic int nbytes(input bit fetch, input op_enum_dmem_size sz);
    if (fetch || sz == SIZE_WORD) return 4;
    return (sz == SIZE_HALF) ? 2 : 1;
  endfunction

  // One transaction from an idle arbiter; dly = BUSY cycle (0-based) on which
  // memory acks, dly >= TMO means memory never acks.
  task automatic run_txn(input string nm, input bit fetch, input bit wr,
                         input op_enum_dmem_size sz, input bit zx,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int dly);
    int          n, a;
    bit          mis, tmo, chk_rd;
    logic [3:0]  be_e;
    logic [31:0] wd_e, rd_e, addr_e;
    longint      v;
    n      = nbytes(fetch, sz);
    a      = int'(addr[1:0]);
    mis    = (a % n) != 0;
    tmo    = dly >= TMO;
    addr_e = {addr[31:2], 2'b00};
    for (int i = 0; i < 4; i++) begin
      be_e[i]       = (i >= a) && (i < a + n);
      wd_e[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    v = 0;
    if (!mis)
      for (int i = 0; i < n; i++) v = v | (longint'(rd[8*(a+i) +: 8]) << (8*i));
    if (!fetch && n < 4 && !zx && v[8*n-1]) v = v - (longint'(1) << (8*n));
    rd_e   = fetch ? rd : v[31:0];
    chk_rd = !mis && !tmo && !(wr && !fetch);

    if (fetch) begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end else begin
      bus.d_req     = 1'b1;
      bus.d_wr      = wr;
      bus.d_size    = sz;
      bus.d_zero_ex = zx;
      bus.d_addr    = addr;
      bus.d_wdata   = wd;
    end
    bus.m_rdata = rd;
    @(negedge clk);

    if (!mis) begin
      check_val({nm, ".m_wr"}, bus.m_wr, (wr && !fetch));
      check_val({nm, ".m_be"}, bus.m_be, be_e);
      if (wr && !fetch) check_val({nm, ".m_wdata"}, bus.m_wdata, wd_e);
      for (int k = 0; k < TMO; k++) begin
        check_val({nm, ".m_req_busy"}, bus.m_req, 1'b1);
        check_val({nm, ".m_addr"}, bus.m_addr, addr_e);
        if (k == dly) bus.m_ack = 1'b1;
        @(negedge clk);
        bus.m_ack = 1'b0;
        if (k == dly) break;
      end
    end

    check_val({nm, ".m_req_resp"}, bus.m_req, 1'b0);
    check_val({nm, ".if_ack"}, bus.if_ack, fetch);
    check_val({nm, ".d_ack"}, bus.d_ack, !fetch);
    check_val({nm, ".err"}, fetch ? bus.if_err : bus.d_err, (mis || tmo));
    if (chk_rd) check_val({nm, ".rdata"}, fetch ? bus.if_rdata : bus.d_rdata, rd_e);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    bus.m_rdata = ~rd;
    @(negedge clk);

    check_val({nm, ".ack_pulse"}, {bus.if_ack, bus.d_ack}, 2'b00);
    if (chk_rd) check_val({nm, ".rdata_hold"}, fetch ? bus.if_rdata : bus.d_rdata, rd_e);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst.m_req", bus.m_req, 1'b0);
    check_val("rst.m_wr", bus.m_wr, 1'b0);
    check_val("rst.m_be", bus.m_be, 4'h0);
    check_val("rst.m_addr", bus.m_addr, 32'h0);
    check_val("rst.m_wdata", bus.m_wdata, 32'h0);
    check_val("rst.acks", {bus.if_ack, bus.if_err, bus.d_ack, bus.d_err}, 4'h0);
    check_val("rst.if_rdata", bus.if_rdata, 32'h0);
    check_val("rst.d_rdata", bus.d_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // simultaneous requests: data first, fetch right after the data response
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b0;
    bus.d_size  = SIZE_WORD;
    bus.d_addr  = 32'h200;
    bus.m_rdata = 32'h1111_2222;
    @(negedge clk);
    check_val("dual.m_req_d", bus.m_req, 1'b1);
    check_val("dual.m_addr_d", bus.m_addr, 32'h200);
    check_val("dual.m_wr_d", bus.m_wr, 1'b0);
    bus.m_ack = 1'b1;
    @(negedge clk);
    bus.m_ack = 1'b0;
    check_val("dual.acks_d", {bus.d_ack, bus.if_ack}, 2'b10);
    check_val("dual.d_rdata", bus.d_rdata, 32'h1111_2222);
    bus.d_req   = 1'b0;
    bus.m_rdata = 32'h3333_4444;
    @(negedge clk);
    check_val("dual.m_req_gap", bus.m_req, 1'b0);
    @(negedge clk);
    check_val("dual.m_req_i", bus.m_req, 1'b1);
    check_val("dual.m_addr_i", bus.m_addr, 32'h100);
    check_val("dual.m_be_i", bus.m_be, 4'hF);
    bus.m_ack = 1'b1;
    @(negedge clk);
    bus.m_ack = 1'b0;
    check_val("dual.acks_i", {bus.d_ack, bus.if_ack, bus.if_err}, 3'b010);
    check_val("dual.if_rdata", bus.if_rdata, 32'h3333_4444);
    bus.if_req = 1'b0;
    @(negedge clk);

    run_txn("sb203", 1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'h203, 32'h0000_00A5, 32'h0, 0);
    run_txn("lb2", 1'b0, 1'b0, SIZE_BYTE, 1'b0, 32'h2, 32'h0, 32'h80FF_7F01, 0);
    run_txn("lbu3", 1'b0, 1'b0, SIZE_BYTE, 1'b1, 32'h3, 32'h0, 32'h80FF_7F01, 1);
    run_txn("lh2", 1'b0, 1'b0, SIZE_HALF, 1'b0, 32'h2, 32'h0, 32'h80FF_7F01, 2);
    run_txn("sh2", 1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h1002, 32'hDEAD_BEEF, 32'h0, 0);
    run_txn("lw6_mis", 1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h6, 32'h0, 32'h0, 0);
    run_txn("lh1_mis", 1'b0, 1'b0, SIZE_HALF, 1'b0, 32'h41, 32'h0, 32'h0, 0);
    run_txn("if_mis", 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h102, 32'h0, 32'h0, 0);
    run_txn("if_tmo", 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h300, 32'h0, 32'hCAFE_F00D, 99);
    run_txn("if_ack15", 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h304, 32'h0, 32'h1234_5678, TMO - 1);

    // reset in the middle of a data access
    bus.d_req  = 1'b1;
    bus.d_wr   = 1'b0;
    bus.d_size = SIZE_WORD;
    bus.d_addr = 32'h40;
    @(negedge clk);
    check_val("rstmid.m_req_before", bus.m_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rstmid.m_req", bus.m_req, 1'b0);
    check_val("rstmid.d_ack", bus.d_ack, 1'b0);
    bus.d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rstmid.d_ack_after", {bus.d_ack, bus.m_req}, 2'b00);
    run_txn("rstmid.post", 1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h44, 32'h0, 32'h5555_AAAA, 0);

    for (int t = 0; t < 60; t++) begin
      bit               f, w, z;
      op_enum_dmem_size s;
      int               r, d;
      f = ($urandom_range(0, 2) == 0);
      w = f ? 1'b0 : 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      s = op_enum_dmem_size'($urandom_range(0, 2));
      r = int'($urandom_range(0, 9));
      if (r < 6)       d = r;
      else if (r == 6) d = TMO - 1;
      else if (r == 7) d = TMO + 2;
      else             d = int'($urandom_range(0, TMO - 1));
      run_txn($sformatf("rnd%0d", t), f, w, s, z, $urandom, $urandom, $urandom, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
